// File: rtl/axi_if.sv
// rtl/axi_if.sv - AXI4 write-channel (AW/W/B) bundle with manager and subordinate views
interface axi_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 8,
    parameter int UW = 32
);
    logic [IW-1:0]   awid;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [UW-1:0]   awuser;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic [UW-1:0]   buser;
    logic            bvalid;
    logic            bready;

    modport w_sub (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready
    );

    modport w_mgr (
        output awid, awaddr, awlen, awsize, awburst, awlock, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sub_wr.sv
// rtl/axi_sub_wr.sv - AXI4 write subordinate driving a simple dv/addr/wdata/wstrb component port
module axi_sub_wr #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 8,
    parameter int UW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_if.w_sub            s_axi_w_if,
    output logic            dv,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] wstrb,
    output logic [UW-1:0]   user,
    output logic [IW-1:0]   id,
    output logic            last,
    input  logic            hld,
    input  logic            err
);
    localparam int         MAX_SIZE = $clog2(DW/8);
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t        state;
    logic          awready_r;
    logic          bvalid_r;
    logic [1:0]    bresp_r;
    logic [IW-1:0] bid_r;
    logic [AW-1:0] addr_r;
    logic [1:0]    burst_r;
    logic [2:0]    size_r;
    logic [7:0]    len_r;
    logic [UW-1:0] user_r;
    logic [IW-1:0] id_r;
    logic [7:0]    beat_cnt;
    logic          err_sticky;
    logic          illegal_r;

    logic          in_data;
    logic          is_last;
    logic          consume;
    logic          wlast_bad;
    logic          illegal_aw;
    logic [AW-1:0] size_bytes;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] next_addr;

    // Lock is accepted for compatibility only; locked writes get a plain OKAY.
    logic unused_awlock;
    assign unused_awlock = s_axi_w_if.awlock;

    assign in_data   = (state == DATA);
    assign is_last   = (beat_cnt == len_r);
    assign wlast_bad = (s_axi_w_if.wlast != is_last);

    // Illegal bursts are drained at full rate and never reach the component.
    assign s_axi_w_if.wready = in_data && (illegal_r || !hld);
    assign consume           = in_data && s_axi_w_if.wvalid && s_axi_w_if.wready;

    assign dv    = in_data && !illegal_r && s_axi_w_if.wvalid;
    assign addr  = addr_r;
    assign wdata = s_axi_w_if.wdata;
    assign wstrb = s_axi_w_if.wstrb;
    assign user  = user_r;
    assign id    = id_r;
    assign last  = in_data && is_last;

    assign s_axi_w_if.awready = awready_r;
    assign s_axi_w_if.bvalid  = bvalid_r;
    assign s_axi_w_if.bresp   = bresp_r;
    assign s_axi_w_if.bid     = bid_r;
    assign s_axi_w_if.buser   = '0;

    assign illegal_aw = (s_axi_w_if.awburst == 2'b11) ||
                        ((s_axi_w_if.awburst == 2'b10) &&
                         !((s_axi_w_if.awlen == 8'd1) || (s_axi_w_if.awlen == 8'd3) ||
                           (s_axi_w_if.awlen == 8'd7) || (s_axi_w_if.awlen == 8'd15))) ||
                        (int'(s_axi_w_if.awsize) > MAX_SIZE);

    always_comb begin
        size_bytes = AW'(1) << size_r;
        wrap_mask  = ((AW'(len_r) + AW'(1)) << size_r) - AW'(1);
        next_addr  = addr_r;
        case (burst_r)
            2'b00:   next_addr = addr_r;
            2'b10:   next_addr = (addr_r & ~wrap_mask) | ((addr_r + size_bytes) & wrap_mask);
            default: next_addr = (addr_r & ~(size_bytes - AW'(1))) + size_bytes;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            awready_r  <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= OKAY;
            bid_r      <= '0;
            addr_r     <= '0;
            burst_r    <= '0;
            size_r     <= '0;
            len_r      <= '0;
            user_r     <= '0;
            id_r       <= '0;
            beat_cnt   <= '0;
            err_sticky <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    awready_r <= 1'b1;
                    if (s_axi_w_if.awvalid && awready_r) begin
                        awready_r  <= 1'b0;
                        addr_r     <= s_axi_w_if.awaddr;
                        burst_r    <= s_axi_w_if.awburst;
                        size_r     <= s_axi_w_if.awsize;
                        len_r      <= s_axi_w_if.awlen;
                        user_r     <= s_axi_w_if.awuser;
                        id_r       <= s_axi_w_if.awid;
                        beat_cnt   <= '0;
                        err_sticky <= 1'b0;
                        illegal_r  <= illegal_aw;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (consume) begin
                        beat_cnt   <= beat_cnt + 8'd1;
                        addr_r     <= next_addr;
                        err_sticky <= err_sticky | err | wlast_bad;
                        // Burst length is governed by awlen; wlast only feeds the error flag.
                        if (is_last) begin
                            state    <= RESP;
                            bvalid_r <= 1'b1;
                            bid_r    <= id_r;
                            bresp_r  <= (err_sticky || err || wlast_bad || illegal_r) ? SLVERR : OKAY;
                        end
                    end
                end
                RESP: begin
                    if (s_axi_w_if.bready) begin
                        bvalid_r <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
